// File: rtl/axis_frame_defs.sv
// Shared definitions for the AXI-Stream frame checker and stream-test sources.
// FSM state encoding plus LFSR seed/tap constants and step function.
package axis_frame_defs;

  typedef enum logic {
    SEEK     = 1'b0,
    IN_FRAME = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16_ready.sv
// 16-bit Fibonacci LFSR producing a pseudo-random ready/valid bit.
// Advances on every enabled cycle; a non-zero seed keeps it out of zero.
module lfsr16_ready
  import axis_frame_defs::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic ce_i,
  output logic ready_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d  = ce_i ? lfsr_next(lfsr_q) : lfsr_q;
  assign ready_o = lfsr_q[0];

  // Shift register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream frame sink: checks frame length and tuser/tlast placement,
// pulses pass/error flags, keeps saturating counts and the last good sum.
module axis_frame_checker
  import axis_frame_defs::*;
#(
  parameter int DW         = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int CW         = 16,
  parameter int READY_MODE = 0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 ce,
  input  logic [DW-1:0]                        tdata_s,
  input  logic                                 tuser_s,
  input  logic                                 tlast_s,
  input  logic                                 tvalid_s,
  output logic                                 tready_s,
  output logic                                 frame_ok,
  output logic                                 err_short,
  output logic                                 err_long,
  output logic                                 err_sof,
  output logic                                 in_frame,
  output logic [CW-1:0]                        frame_cnt,
  output logic [CW-1:0]                        err_cnt,
  output logic signed [DW+$clog2(FRAME_LEN)-1:0] frame_sum
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int AW = DW + IW;
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] sum_q;
  logic signed [AW-1:0] dext;
  logic                 ok_q, short_q, long_q, sof_q;
  logic                 ok_d, short_d, long_d, sof_d;
  logic [CW-1:0]        fcnt_q, ecnt_q;
  logic                 rdy_q;
  logic                 lfsr_bit;
  logic                 beat;
  logic                 at_last;

  generate
    if (READY_MODE == 1) begin : g_lfsr
      lfsr16_ready u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_i    (ce),
        .ready_o (lfsr_bit)
      );
    end else begin : g_const
      assign lfsr_bit = 1'b1;
    end
  endgenerate

  // rdy_q keeps tready_s low while in reset and for the reset cycle itself.
  assign tready_s = ce & rdy_q & lfsr_bit;
  assign beat     = tvalid_s & tready_s;
  assign dext     = {{IW{tdata_s[DW-1]}}, tdata_s};
  assign at_last  = (idx_q == IDX_LAST);

  // Per-beat frame decision; tuser wins over tlast, tlast over length.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ok_d    = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    sof_d   = 1'b0;
    if (beat) begin
      unique case (state_q)
        SEEK: begin
          if (tuser_s) begin
            idx_d = IW'(1);
            acc_d = dext;
            if (tlast_s) short_d = 1'b1;
            else         state_d = IN_FRAME;
          end
        end
        IN_FRAME: begin
          if (tuser_s) begin
            sof_d = 1'b1;
            idx_d = IW'(1);
            acc_d = dext;
          end else if (tlast_s && at_last) begin
            ok_d    = 1'b1;
            state_d = SEEK;
          end else if (tlast_s) begin
            short_d = 1'b1;
            state_d = SEEK;
          end else if (at_last) begin
            long_d  = 1'b1;
            state_d = SEEK;
          end else begin
            idx_d = idx_q + IW'(1);
            acc_d = acc_q + dext;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  // FSM, datapath and registered pulses; pulses clear every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEEK;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      ok_q    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      sof_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      if (ok_d) sum_q <= acc_q + dext;
      ok_q    <= ok_d;
      short_q <= short_d;
      long_q  <= long_d;
      sof_q   <= sof_d;
      rdy_q   <= 1'b1;
    end
  end

  // Saturating good-frame and error counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      if (ok_d && fcnt_q != '1)
        fcnt_q <= fcnt_q + CW'(1);
      if ((short_d | long_d | sof_d) && ecnt_q != '1)
        ecnt_q <= ecnt_q + CW'(1);
    end
  end

  assign frame_ok  = ok_q;
  assign err_short = short_q;
  assign err_long  = long_q;
  assign err_sof   = sof_q;
  assign in_frame  = (state_q == IN_FRAME);
  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;
  assign frame_sum = sum_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Scoreboard bench for axis_frame_checker: one instance per ready mode,
// directed frames push expected events, monitors pop and compare.
module tb_axis_frame_checker;

  localparam int DW = 16;
  localparam int FL = 1024;
  localparam int CW = 16;
  localparam int AW = 26;

  localparam logic [3:0] K_OK = 4'b1000;
  localparam logic [3:0] K_SH = 4'b0100;
  localparam logic [3:0] K_LG = 4'b0010;
  localparam logic [3:0] K_SF = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, ce, vld, sel;
  logic [DW-1:0] tdata;
  logic          tuser, tlast;

  logic                 rdy0, ok0, es0, el0, ef0, inf0;
  logic [CW-1:0]        fc0, ec0;
  logic signed [AW-1:0] fs0;
  logic                 rdy1, ok1, es1, el1, ef1, inf1;
  logic [CW-1:0]        fc1, ec1;
  logic signed [AW-1:0] fs1;

  axis_frame_checker #(.DW(DW), .FRAME_LEN(FL), .CW(CW), .READY_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .tdata_s(tdata), .tuser_s(tuser), .tlast_s(tlast),
    .tvalid_s(vld & ~sel), .tready_s(rdy0),
    .frame_ok(ok0), .err_short(es0), .err_long(el0), .err_sof(ef0),
    .in_frame(inf0), .frame_cnt(fc0), .err_cnt(ec0), .frame_sum(fs0)
  );

  axis_frame_checker #(.DW(DW), .FRAME_LEN(FL), .CW(CW), .READY_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .tdata_s(tdata), .tuser_s(tuser), .tlast_s(tlast),
    .tvalid_s(vld & sel), .tready_s(rdy1),
    .frame_ok(ok1), .err_short(es1), .err_long(el1), .err_sof(ef1),
    .in_frame(inf1), .frame_cnt(fc1), .err_cnt(ec1), .frame_sum(fs1)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0] kind;
    longint     sum;
    longint     fc;
    longint     ec;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string nm, input longint act, input longint req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push(input bit s, input logic [3:0] k,
                      input longint sm, input longint fc, input longint ec);
    exp_t e;
    e.kind = k; e.sum = sm; e.fc = fc; e.ec = ec;
    if (s) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    logic [3:0] k;
    k = {ok0, es0, el0, ef0};
    if (reset_n && k != 4'b0) begin
      if (q0.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_event0: got kind %b, required none", k);
      end else begin
        e = q0.pop_front();
        chk("kind0", longint'(k), longint'(e.kind));
        chk("sum0", longint'(fs0), e.sum);
        chk("fcnt0", longint'(fc0), e.fc);
        chk("ecnt0", longint'(ec0), e.ec);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    logic [3:0] k;
    k = {ok1, es1, el1, ef1};
    if (reset_n && k != 4'b0) begin
      if (q1.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_event1: got kind %b, required none", k);
      end else begin
        e = q1.pop_front();
        chk("kind1", longint'(k), longint'(e.kind));
        chk("sum1", longint'(fs1), e.sum);
        chk("fcnt1", longint'(fc1), e.fc);
        chk("ecnt1", longint'(ec1), e.ec);
      end
    end
  end

  task automatic beat(input logic [DW-1:0] d, input bit u, input bit l);
    int n;
    tdata = d; tuser = u; tlast = l; vld = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (sel ? rdy1 : rdy0) break;
      n++;
      if (n > 200) begin
        nvec++; nerr++;
        $display("FAIL beat_timeout: tready 0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n, input logic [DW-1:0] d,
                       input bit u0, input bit ln);
    for (int i = 0; i < n; i++)
      beat(d, u0 && (i == 0), ln && (i == n - 1));
  endtask

  task automatic idle(input int n);
    vld = 1'b0; tuser = 1'b0; tlast = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero0(input string nm);
    chk({nm, "_tready"}, longint'(rdy0), 0);
    chk({nm, "_pulses"}, longint'({ok0, es0, el0, ef0}), 0);
    chk({nm, "_in_frame"}, longint'(inf0), 0);
    chk({nm, "_fcnt"}, longint'(fc0), 0);
    chk({nm, "_ecnt"}, longint'(ec0), 0);
    chk({nm, "_sum"}, longint'(fs0), 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] m;
    reset_n = 1'b0; ce = 1'b1; vld = 1'b0; sel = 1'b0;
    tdata = '0; tuser = 1'b0; tlast = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero0("reset");
    chk("reset_tready1", longint'(rdy1), 0);
    reset_n = 1'b1;

    m = 16'hACE1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
      @(negedge clk);
      chk("tready1_lfsr", longint'(rdy1), longint'(m[0]));
      if (i == 0) chk("tready0_rise", longint'(rdy0), 1);
    end
    @(posedge clk);
    #1;

    push(0, K_OK, 1024, 1, 0);
    push(0, K_OK, 1024, 2, 0);
    frame(FL, 16'd1, 1, 1);
    frame(FL, 16'd1, 1, 1);

    push(0, K_SH, 1024, 2, 1);
    push(0, K_OK, 2048, 3, 1);
    frame(1000, 16'd1, 1, 1);
    frame(FL, 16'd2, 1, 1);

    push(0, K_LG, 2048, 3, 2);
    push(0, K_OK, 1024, 4, 2);
    frame(FL, 16'd1, 1, 0);
    frame(6, 16'd1, 0, 1);
    frame(FL, 16'd1, 1, 1);

    push(0, K_SF, 1024, 4, 3);
    push(0, K_OK, -3072, 5, 3);
    frame(499, 16'd1, 1, 0);
    frame(FL, 16'hFFFD, 1, 1);

    push(0, K_SH, -3072, 5, 4);
    frame(1, 16'd5, 1, 1);
    idle(2);
    chk("seek_short_in_frame", longint'(inf0), 0);

    frame(300, 16'd1, 1, 0);
    chk("mid_in_frame", longint'(inf0), 1);
    reset_n = 1'b0;
    #1;
    chk_zero0("midreset");
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push(0, K_OK, 1024, 1, 0);
    frame(FL, 16'd1, 1, 1);
    idle(3);

    sel = 1'b1;
    push(1, K_OK, 1024, 1, 0);
    push(1, K_OK, 1024, 2, 0);
    frame(500, 16'd1, 1, 0);
    ce = 1'b0; tuser = 1'b1; tlast = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("ce_low_tready1", longint'(rdy1), 0);
      chk("ce_low_in_frame1", longint'(inf1), 1);
    end
    @(posedge clk);
    #1;
    ce = 1'b1;
    frame(524, 16'd1, 0, 1);
    frame(FL, 16'd1, 1, 1);
    idle(5);

    chk("pending0", longint'(q0.size()), 0);
    chk("pending1", longint'(q1.size()), 0);
    chk("final_fcnt1", longint'(fc1), 2);
    chk("final_fcnt0", longint'(fc0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
